cpu_writeback_arbiter: RTL and testbench
========================================

# cpu_writeback_arbiter

Drives the single write port (`a3`/`wd3`/`we3`) of `cpu_register_file` for the CPU. It merges two producers into one registered write per cycle: single-cycle ALU results, which have fixed priority, and variable-latency load results, which are buffered in a small FIFO. It also keeps a pending-load scoreboard, which decode queries to stall on operands whose load has not yet been written back.

## Interface
- `DEPTH`, 2: load-result FIFO entries; must be a power of 2, ≥2.
- `clk` in 1: clock; all state updates on posedge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `alu_valid` in 1: ALU result present this cycle; always accepted, no ready.
- `alu_rd` in 5: ALU destination register.
- `alu_data` in 32: ALU result.
- `ld_issue` in 1: load issued this cycle; marks `ld_issue_rd` pending.
- `ld_issue_rd` in 5: destination of the issued load.
- `ld_valid` in 1: load result offered.
- `ld_ready` out 1: FIFO can accept; equals `!full`, combinational.
- `ld_rd` in 5: load result destination.
- `ld_data` in 32: load result data.
- `chk_a1`, `chk_a2` in 5: decode operand addresses.
- `busy1`, `busy2` out 1: operand has an outstanding load; combinational.
- `a3` out 5: register-file write address; registered.
- `wd3` out 32: register-file write data; registered.
- `we3` out 1: register-file write enable; registered.
- `ld_count` out log2(DEPTH)+1: FIFO occupancy.

## Operation
- **Load push:** occurs on a posedge with `ld_valid && ld_ready`, writing `{ld_rd, ld_data}` at the tail.
  - `ld_ready` is 0 whenever the FIFO is full, even if a pop happens the same cycle. There is no full-cycle push-through.
- **Write select,** evaluated each cycle, then registered at the posedge:
  - If `alu_valid`: next `{a3, wd3} = {alu_rd, alu_data}`, `we3 = (alu_rd != 0)`, source = ALU.
  - Else if the FIFO is non-empty: pop the head, next `{a3, wd3}` = head, `we3 = (head_rd != 0)`, source = LOAD. A head with rd=0 is still consumed.
  - Else: `we3 = 0`, and `a3`/`wd3` hold their previous values.
- **No bypass:** a load pushed into an empty FIFO is not popped in the same cycle.
- **Starvation:** continuous `alu_valid` starves loads indefinitely. Upstream guarantees ALU bubbles; the block does not age-arbitrate.
- **Scoreboard:** `pending[31:1]` registers; x0 is never pending.
  - **Set:** at the posedge where `ld_issue && ld_issue_rd != 0`.
  - **Clear:** at the posedge where the register file commits a LOAD-sourced write, i.e. while registered `we3 = 1` and source = LOAD, it clears `pending[a3]`. This is the edge after the pop.
  - **Set and clear on the same register in the same edge:** set wins.
  - **Issue to an already-pending register:** the bit stays set, and the first completion clears it. Upstream must not issue two loads to the same rd in flight.
  - ALU writes never touch `pending`.
- **Scoreboard query:** `busy1 = (chk_a1 != 0) && pending[chk_a1]`; `busy2` is the same with `chk_a2`. The query reflects only registered state; an issue in the current cycle is not visible until the next cycle.
- **FIFO indexing:** head and tail pointers are log2(DEPTH) bits and wrap modulo DEPTH. Occupancy is tracked by a separate counter.

## Timing
- **Reset** (`rst_n = 0`, asynchronous):
  - Outputs: `we3 = 0`, `a3 = 0`, `wd3 = 0`, `ld_count = 0`, `ld_ready = 1`, `busy1 = busy2 = 0`.
  - State: FIFO empty, pointers 0, `pending` all 0, source = ALU.
  - Reset mid-operation discards buffered loads and pending bits with no write emitted.
- **ALU latency:** `alu_valid` sampled at edge N → `we3` high during cycle N..N+1 → register file updated at edge N+1.
- **Load latency** (empty FIFO, no ALU contention): push at edge E → pop at E+1 → `we3` high E+1..E+2 → register written and pending cleared at E+2. `busy` drops in the cycle after E+2, when the register file already holds the data.
- **Throughput:** at most one register-file write per cycle. Sustained loads run at one per cycle once the FIFO is non-empty.
- **Push and pop on the same edge:** occupancy is unchanged. Push alone increments it, pop alone decrements it.

## Test plan
- **Reset:** assert `rst_n = 0` mid-stream with 2 loads buffered → `we3 = 0` and `ld_count = 0` immediately; after release, `ld_ready = 1` and `busy1 = 0` for all registers.
- **ALU path:** `alu_valid = 1`, `alu_rd = 5`, `alu_data = 0xDEADBEEF` at edge N → `a3 = 5`, `wd3 = 0xDEADBEEF`, `we3 = 1` for exactly one cycle. With `alu_rd = 0` → `we3 = 0`.
- **Load scoreboard:**
  - Issue a load to x7, then query `chk_a1 = 7` → `busy1 = 1`.
  - Return `ld_rd = 7`, `ld_data = 0x12345678` → write appears 1 cycle after the push.
  - `busy1` falls exactly after the commit edge.
  - Issue and clear to x7 on the same edge → `busy1` stays 1.
- **Contention/full:**
  - Hold `alu_valid` high for 4 cycles while offering 3 loads → `ld_ready` drops after 2 pushes (DEPTH=2), and ALU writes are emitted every cycle.
  - Drop `alu_valid` → the buffered loads drain in FIFO order on consecutive cycles.
- **Wrap-around:** stream 9 loads with random rd/data through DEPTH=2 under random ALU and `ld_valid` traffic → every load is written once, in order, with matching data; `ld_count` never exceeds 2; all pending bits return to 0.

Source files
------------

// File: rtl/cpu_writeback_arbiter_if.sv
// Write-back bus between the CPU datapath (producer side) and the arbiter
// that owns the register-file write port and the pending-load scoreboard.
interface cpu_writeback_arbiter_if #(
  parameter int DEPTH  = 2,
  parameter int DATA_W = 32
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic              alu_valid;
  logic [4:0]        alu_rd;
  logic [DATA_W-1:0] alu_data;
  logic              ld_issue;
  logic [4:0]        ld_issue_rd;
  logic              ld_valid;
  logic              ld_ready;
  logic [4:0]        ld_rd;
  logic [DATA_W-1:0] ld_data;
  logic [4:0]        chk_a1;
  logic [4:0]        chk_a2;
  logic              busy1;
  logic              busy2;
  logic [4:0]        a3;
  logic [DATA_W-1:0] wd3;
  logic              we3;
  logic [CW-1:0]     ld_count;

  modport master (
    output alu_valid, alu_rd, alu_data, ld_issue, ld_issue_rd,
           ld_valid, ld_rd, ld_data, chk_a1, chk_a2,
    input  ld_ready, busy1, busy2, a3, wd3, we3, ld_count
  );

  modport slave (
    input  alu_valid, alu_rd, alu_data, ld_issue, ld_issue_rd,
           ld_valid, ld_rd, ld_data, chk_a1, chk_a2,
    output ld_ready, busy1, busy2, a3, wd3, we3, ld_count
  );
endinterface

// File: rtl/cpu_writeback_arbiter.sv
// Merges ALU results (fixed priority) and buffered load results into one
// registered register-file write per cycle; tracks loads awaiting write-back.
module cpu_writeback_arbiter #(
  parameter int DEPTH  = 2,
  parameter int DATA_W = 32
) (
  input logic                    clk,
  input logic                    rst_n,
  cpu_writeback_arbiter_if.slave bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [4:0]        fifo_rd   [DEPTH];
  logic [DATA_W-1:0] fifo_data [DEPTH];
  logic [PW-1:0]     head_p0;
  logic [PW-1:0]     tail_p0;
  logic [CW-1:0]     count_p0;
  logic              full;
  logic              empty;
  logic              push;
  logic              pop;

  logic [4:0]        a3_p1;
  logic [DATA_W-1:0] wd3_p1;
  logic              we3_p1;
  logic              src_ld_p1;
  logic [31:0]       pending_p1;
  logic [31:0]       pending_nxt;

  // Stage p0: load FIFO (push never bypasses to pop; occupancy is registered)
  assign full  = (count_p0 == FULL_CNT);
  assign empty = (count_p0 == '0);
  assign push  = bus.ld_valid && !full;
  assign pop   = !bus.alu_valid && !empty;

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_rd[tail_p0]   <= bus.ld_rd;
      fifo_data[tail_p0] <= bus.ld_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_p0  <= '0;
      tail_p0  <= '0;
      count_p0 <= '0;
    end else begin
      if (push) tail_p0 <= tail_p0 + 1'b1;
      if (pop)  head_p0 <= head_p0 + 1'b1;
      case ({push, pop})
        2'b10:   count_p0 <= count_p0 + 1'b1;
        2'b01:   count_p0 <= count_p0 - 1'b1;
        default: count_p0 <= count_p0;
      endcase
    end
  end

  // Stage p1: registered write port; idle cycles keep a3/wd3 and drop we3
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a3_p1     <= '0;
      wd3_p1    <= '0;
      we3_p1    <= 1'b0;
      src_ld_p1 <= 1'b0;
    end else if (bus.alu_valid) begin
      a3_p1     <= bus.alu_rd;
      wd3_p1    <= bus.alu_data;
      we3_p1    <= (bus.alu_rd != 5'd0);
      src_ld_p1 <= 1'b0;
    end else if (pop) begin
      a3_p1     <= fifo_rd[head_p0];
      wd3_p1    <= fifo_data[head_p0];
      we3_p1    <= (fifo_rd[head_p0] != 5'd0);
      src_ld_p1 <= 1'b1;
    end else begin
      we3_p1    <= 1'b0;
    end
  end

  // Scoreboard clears on the commit edge of a load write; a same-edge issue wins.
  always_comb begin
    pending_nxt = pending_p1;
    if (we3_p1 && src_ld_p1) pending_nxt[a3_p1] = 1'b0;
    if (bus.ld_issue && (bus.ld_issue_rd != 5'd0)) pending_nxt[bus.ld_issue_rd] = 1'b1;
    pending_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pending_p1 <= '0;
    else        pending_p1 <= pending_nxt;
  end

  assign bus.ld_ready = !full;
  assign bus.ld_count = count_p0;
  assign bus.a3       = a3_p1;
  assign bus.wd3      = wd3_p1;
  assign bus.we3      = we3_p1;
  assign bus.busy1    = (bus.chk_a1 != 5'd0) && pending_p1[bus.chk_a1];
  assign bus.busy2    = (bus.chk_a2 != 5'd0) && pending_p1[bus.chk_a2];
endmodule

// File: tb/tb_cpu_writeback_arbiter.sv
// Directed bench for cpu_writeback_arbiter: reset, ALU path, load scoreboard,
// ALU/load contention with a full FIFO, and a randomised wrap-around stream.
module tb_cpu_writeback_arbiter;
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  int   n_checks = 0;
  int   n_fail = 0;

  cpu_writeback_arbiter_if #(.DEPTH(2), .DATA_W(32)) bus ();

  cpu_writeback_arbiter #(.DEPTH(2), .DATA_W(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.alu_valid   = 1'b0;
    bus.alu_rd      = 5'd0;
    bus.alu_data    = 32'd0;
    bus.ld_issue    = 1'b0;
    bus.ld_issue_rd = 5'd0;
    bus.ld_valid    = 1'b0;
    bus.ld_rd       = 5'd0;
    bus.ld_data     = 32'd0;
    bus.chk_a1      = 5'd0;
    bus.chk_a2      = 5'd0;
  endtask

  task automatic test_reset();
    idle();
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if (bus.we3 !== 1'b0 || bus.a3 !== 5'd0 || bus.wd3 !== 32'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: we3=%b a3=%0d wd3=%h, required 0/0/0", bus.we3, bus.a3, bus.wd3);
    end
    n_checks++;
    if (bus.ld_count !== 2'd0 || bus.ld_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_fifo: ld_count=%0d ld_ready=%b, required 0/1", bus.ld_count, bus.ld_ready);
    end
    cycle();
    rst_n = 1'b1;
    cycle();
    // Buffer two loads behind ALU traffic, with both destinations pending.
    bus.alu_valid = 1'b1; bus.alu_rd = 5'd1; bus.alu_data = 32'h1111_0000;
    bus.ld_issue = 1'b1; bus.ld_issue_rd = 5'd3;
    bus.ld_valid = 1'b1; bus.ld_rd = 5'd3; bus.ld_data = 32'hAAAA_0003;
    cycle();
    bus.ld_issue_rd = 5'd4; bus.ld_rd = 5'd4; bus.ld_data = 32'hAAAA_0004;
    cycle();
    idle();
    #1;
    n_checks++;
    if (bus.ld_count !== 2'd2 || bus.we3 !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_prefill: ld_count=%0d we3=%b, required 2/1", bus.ld_count, bus.we3);
    end
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (bus.we3 !== 1'b0 || bus.ld_count !== 2'd0) begin
      n_fail++;
      $display("FAIL reset_async: we3=%b ld_count=%0d, required 0/0", bus.we3, bus.ld_count);
    end
    cycle();
    rst_n = 1'b1;
    cycle();
    n_checks++;
    if (bus.ld_ready !== 1'b1 || bus.we3 !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_release: ld_ready=%b we3=%b, required 1/0", bus.ld_ready, bus.we3);
    end
    for (int r = 0; r < 32; r++) begin
      bus.chk_a1 = 5'(r); bus.chk_a2 = 5'(r);
      #1;
      n_checks++;
      if (bus.busy1 !== 1'b0 || bus.busy2 !== 1'b0) begin
        n_fail++;
        $display("FAIL reset_busy x%0d: busy1=%b busy2=%b, required 0/0", r, bus.busy1, bus.busy2);
      end
    end
    idle();
  endtask

  task automatic test_alu();
    idle();
    bus.alu_valid = 1'b1; bus.alu_rd = 5'd5; bus.alu_data = 32'hDEAD_BEEF;
    cycle();
    idle();
    n_checks++;
    if (bus.we3 !== 1'b1 || bus.a3 !== 5'd5 || bus.wd3 !== 32'hDEAD_BEEF) begin
      n_fail++;
      $display("FAIL alu_write: we3=%b a3=%0d wd3=%h, required 1/5/deadbeef", bus.we3, bus.a3, bus.wd3);
    end
    cycle();
    n_checks++;
    if (bus.we3 !== 1'b0 || bus.a3 !== 5'd5 || bus.wd3 !== 32'hDEAD_BEEF) begin
      n_fail++;
      $display("FAIL alu_one_cycle: we3=%b a3=%0d wd3=%h, required 0/5/deadbeef", bus.we3, bus.a3, bus.wd3);
    end
    bus.alu_valid = 1'b1; bus.alu_rd = 5'd0; bus.alu_data = 32'h0BAD_F00D;
    cycle();
    idle();
    n_checks++;
    if (bus.we3 !== 1'b0 || bus.a3 !== 5'd0) begin
      n_fail++;
      $display("FAIL alu_x0: we3=%b a3=%0d, required 0/0", bus.we3, bus.a3);
    end
  endtask

  task automatic test_load_scoreboard();
    idle();
    bus.chk_a1 = 5'd7;
    bus.ld_issue = 1'b1; bus.ld_issue_rd = 5'd7;
    #1;
    n_checks++;
    if (bus.busy1 !== 1'b0) begin
      n_fail++;
      $display("FAIL sb_issue_same_cycle: busy1=%b, required 0", bus.busy1);
    end
    cycle();
    bus.ld_issue = 1'b0;
    #1;
    n_checks++;
    if (bus.busy1 !== 1'b1) begin
      n_fail++;
      $display("FAIL sb_pending: busy1=%b, required 1", bus.busy1);
    end
    bus.ld_valid = 1'b1; bus.ld_rd = 5'd7; bus.ld_data = 32'h1234_5678;
    cycle();
    bus.ld_valid = 1'b0;
    n_checks++;
    if (bus.we3 !== 1'b0 || bus.ld_count !== 2'd1) begin
      n_fail++;
      $display("FAIL sb_push_no_bypass: we3=%b ld_count=%0d, required 0/1", bus.we3, bus.ld_count);
    end
    cycle();
    n_checks++;
    if (bus.we3 !== 1'b1 || bus.a3 !== 5'd7 || bus.wd3 !== 32'h1234_5678 || bus.ld_count !== 2'd0) begin
      n_fail++;
      $display("FAIL sb_load_write: we3=%b a3=%0d wd3=%h cnt=%0d, required 1/7/12345678/0",
               bus.we3, bus.a3, bus.wd3, bus.ld_count);
    end
    n_checks++;
    if (bus.busy1 !== 1'b1) begin
      n_fail++;
      $display("FAIL sb_busy_before_commit: busy1=%b, required 1", bus.busy1);
    end
    cycle();
    n_checks++;
    if (bus.busy1 !== 1'b0 || bus.we3 !== 1'b0) begin
      n_fail++;
      $display("FAIL sb_busy_after_commit: busy1=%b we3=%b, required 0/0", bus.busy1, bus.we3);
    end
    // Same-edge set and clear on x7.
    bus.ld_issue = 1'b1; bus.ld_issue_rd = 5'd7;
    cycle();
    bus.ld_issue = 1'b0;
    bus.ld_valid = 1'b1; bus.ld_rd = 5'd7; bus.ld_data = 32'h0000_0077;
    cycle();
    bus.ld_valid = 1'b0;
    cycle();
    bus.ld_issue = 1'b1; bus.ld_issue_rd = 5'd7;
    cycle();
    bus.ld_issue = 1'b0;
    n_checks++;
    if (bus.busy1 !== 1'b1) begin
      n_fail++;
      $display("FAIL sb_set_wins: busy1=%b, required 1", bus.busy1);
    end
    bus.ld_valid = 1'b1; bus.ld_rd = 5'd7; bus.ld_data = 32'h0000_0078;
    cycle();
    bus.ld_valid = 1'b0;
    cycle();
    cycle();
    n_checks++;
    if (bus.busy1 !== 1'b0) begin
      n_fail++;
      $display("FAIL sb_final_clear: busy1=%b, required 0", bus.busy1);
    end
    idle();
  endtask

  task automatic test_contention();
    logic [31:0] ldat [3];
    int li;
    ldat[0] = 32'hC0DE_0020; ldat[1] = 32'hC0DE_0021; ldat[2] = 32'hC0DE_0022;
    li = 0;
    idle();
    for (int i = 0; i < 4; i++) begin
      bus.alu_valid = 1'b1; bus.alu_rd = 5'(10 + i); bus.alu_data = 32'(100 + i);
      bus.ld_valid = 1'b1; bus.ld_rd = 5'(20 + li); bus.ld_data = ldat[li];
      #1;
      n_checks++;
      if (bus.ld_ready !== (i < 2)) begin
        n_fail++;
        $display("FAIL cont_ready[%0d]: ld_ready=%b, required %0d", i, bus.ld_ready, (i < 2));
      end
      if (bus.ld_ready === 1'b1) li++;
      cycle();
      n_checks++;
      if (bus.we3 !== 1'b1 || bus.a3 !== 5'(10 + i) || bus.wd3 !== 32'(100 + i)) begin
        n_fail++;
        $display("FAIL cont_alu[%0d]: we3=%b a3=%0d wd3=%0d, required 1/%0d/%0d",
                 i, bus.we3, bus.a3, bus.wd3, 10 + i, 100 + i);
      end
    end
    n_checks++;
    if (bus.ld_count !== 2'd2) begin
      n_fail++;
      $display("FAIL cont_full: ld_count=%0d, required 2", bus.ld_count);
    end
    // Drain with the third load still offered: no push while full, even on a pop.
    bus.alu_valid = 1'b0;
    bus.ld_valid = 1'b1; bus.ld_rd = 5'd22; bus.ld_data = ldat[2];
    #1;
    n_checks++;
    if (bus.ld_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL cont_no_pushthrough: ld_ready=%b, required 0", bus.ld_ready);
    end
    cycle();
    n_checks++;
    if (bus.we3 !== 1'b1 || bus.a3 !== 5'd20 || bus.wd3 !== ldat[0] || bus.ld_count !== 2'd1) begin
      n_fail++;
      $display("FAIL cont_drain0: we3=%b a3=%0d wd3=%h cnt=%0d, required 1/20/%h/1",
               bus.we3, bus.a3, bus.wd3, bus.ld_count, ldat[0]);
    end
    cycle();
    bus.ld_valid = 1'b0;
    n_checks++;
    if (bus.we3 !== 1'b1 || bus.a3 !== 5'd21 || bus.wd3 !== ldat[1] || bus.ld_count !== 2'd1) begin
      n_fail++;
      $display("FAIL cont_drain1: we3=%b a3=%0d wd3=%h cnt=%0d, required 1/21/%h/1",
               bus.we3, bus.a3, bus.wd3, bus.ld_count, ldat[1]);
    end
    cycle();
    n_checks++;
    if (bus.we3 !== 1'b1 || bus.a3 !== 5'd22 || bus.wd3 !== ldat[2] || bus.ld_count !== 2'd0) begin
      n_fail++;
      $display("FAIL cont_drain2: we3=%b a3=%0d wd3=%h cnt=%0d, required 1/22/%h/0",
               bus.we3, bus.a3, bus.wd3, bus.ld_count, ldat[2]);
    end
    cycle();
    n_checks++;
    if (bus.we3 !== 1'b0) begin
      n_fail++;
      $display("FAIL cont_idle: we3=%b, required 0", bus.we3);
    end
    idle();
  endtask

  task automatic test_wrap_around();
    logic [4:0]  rds  [9];
    logic [31:0] dats [9];
    logic [36:0] q [$];
    logic [36:0] hd;
    logic [4:0]  exp_a3;
    logic [31:0] exp_wd3;
    logic        exp_we3;
    logic        a_v;
    logic        l_v;
    int          base;
    int          sent;
    int          written;
    int          had;
    int          cyc;
    base = $urandom_range(0, 30);
    for (int i = 0; i < 9; i++) begin
      rds[i]  = 5'(((base + i * 7) % 31) + 1);
      dats[i] = $urandom;
    end
    idle();
    bus.alu_valid = 1'b1;
    cycle();
    exp_a3 = 5'd0; exp_wd3 = 32'd0;
    for (int i = 0; i < 9; i++) begin
      bus.alu_valid = 1'b0;
      bus.ld_issue = 1'b1; bus.ld_issue_rd = rds[i];
      cycle();
    end
    bus.ld_issue = 1'b0;
    sent = 0; written = 0; cyc = 0;
    while ((sent < 9 || q.size() > 0) && cyc < 200) begin
      cyc++;
      a_v = ($urandom_range(0, 1) == 1);
      l_v = (sent < 9) && ($urandom_range(0, 2) != 0);
      bus.alu_valid = a_v;
      bus.alu_rd    = 5'($urandom_range(0, 31));
      bus.alu_data  = $urandom;
      bus.ld_valid  = l_v;
      bus.ld_rd     = (sent < 9) ? rds[sent] : 5'd0;
      bus.ld_data   = (sent < 9) ? dats[sent] : 32'd0;
      #1;
      had = q.size();
      n_checks++;
      if (bus.ld_ready !== (had < 2)) begin
        n_fail++;
        $display("FAIL wrap_ready cyc%0d: ld_ready=%b, required %0d", cyc, bus.ld_ready, (had < 2));
      end
      if (a_v) begin
        exp_a3 = bus.alu_rd; exp_wd3 = bus.alu_data; exp_we3 = (bus.alu_rd != 5'd0);
      end else if (had > 0) begin
        hd = q.pop_front();
        exp_a3 = hd[36:32]; exp_wd3 = hd[31:0]; exp_we3 = (hd[36:32] != 5'd0);
        written++;
      end else begin
        exp_we3 = 1'b0;
      end
      if (l_v && had < 2) begin
        q.push_back({rds[sent], dats[sent]});
        sent++;
      end
      cycle();
      n_checks++;
      if (bus.we3 !== exp_we3 || bus.a3 !== exp_a3 || bus.wd3 !== exp_wd3) begin
        n_fail++;
        $display("FAIL wrap_write cyc%0d: we3=%b a3=%0d wd3=%h, required %b/%0d/%h",
                 cyc, bus.we3, bus.a3, bus.wd3, exp_we3, exp_a3, exp_wd3);
      end
      n_checks++;
      if (bus.ld_count !== 2'(q.size())) begin
        n_fail++;
        $display("FAIL wrap_count cyc%0d: ld_count=%0d, required %0d", cyc, bus.ld_count, q.size());
      end
    end
    idle();
    n_checks++;
    if (written != 9 || sent != 9) begin
      n_fail++;
      $display("FAIL wrap_complete: written=%0d sent=%0d, required 9/9 within cycle budget", written, sent);
    end
    cycle();
    cycle();
    for (int r = 1; r < 32; r++) begin
      bus.chk_a1 = 5'(r); bus.chk_a2 = 5'(r);
      #1;
      n_checks++;
      if (bus.busy1 !== 1'b0 || bus.busy2 !== 1'b0) begin
        n_fail++;
        $display("FAIL wrap_pending x%0d: busy1=%b busy2=%b, required 0/0", r, bus.busy1, bus.busy2);
      end
    end
    idle();
  endtask

  initial begin
    idle();
    test_reset();
    test_alu();
    test_load_scoreboard();
    test_contention();
    test_wrap_around();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
